inst_fetch: RTL and testbench

//   Instruction-fetch initiator for the combinational instruction ROM.
//   - Owns the PC and drives ce_o/pc_o to the ROM; inst_i returns in the same cycle.
//   - Captures each {pc, inst} pair into a small FIFO and hands it to decode over a valid/ready handshake.
//   - Sits between the ctrl unit (stall), the ROM, and the ID stage. Accepts branch redirects from ID/EX.

---
 rtl/inst_fetch_if.sv | 20 ++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch bus: ROM request/response plus the fetch-to-decode valid/ready handshake.
interface inst_fetch_if;
  logic        ce_o;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;

  modport master (
    output ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o,
    input  inst_i, id_ready_i
  );

  modport slave (
    input  ce_o, pc_o, id_valid_o, id_pc_o, id_inst_o,
    output inst_i, id_ready_i
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC to a combinational ROM and buffers {pc, inst} in a FIFO for decode.
// Optional FETCH_ALIGN_CHECK_EN adds a registered misalign_o flag for unaligned branch targets.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         branch_flag_i,
  input  logic [31:0]  branch_target_i,
  inst_fetch_if.master fetch_bus
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic         misalign_o
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  state_t        state_q;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic ce, full, valid, push, pop;

  assign ce    = (state_q == ST_FETCH);
  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign push  = ce & ~stall_i & ~full & ~branch_flag_i;
  assign pop   = valid & fetch_bus.id_ready_i & ~branch_flag_i;

  always_comb begin
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (branch_flag_i) begin
      // Redirect flushes every buffered entry; the target is fetched on the next push.
      pc_d    = {branch_target_i[31:2], 2'b00};
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      pc_mem   <= '{default: '0};
      inst_mem <= '{default: '0};
    end else begin
      state_q <= ST_FETCH;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push) begin
        pc_mem[wr_q]   <= pc_q;
        inst_mem[wr_q] <= fetch_bus.inst_i;
      end
    end
  end

  assign fetch_bus.ce_o       = ce;
  assign fetch_bus.pc_o       = pc_q;
  assign fetch_bus.id_valid_o = valid;
  assign fetch_bus.id_pc_o    = valid ? pc_mem[rd_q]   : '0;
  assign fetch_bus.id_inst_o  = valid ? inst_mem[rd_q] : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= branch_flag_i & (|branch_target_i[1:0]);
    end
  end

  assign misalign_o = misalign_q;
`else
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^branch_target_i[1:0];
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: queue-based reference model, directed scenarios, then random traffic.
module tb_inst_fetch;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] tgt;

  inst_fetch_if fb ();
  inst_fetch_if fbw ();

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis, mis_w;
`endif

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_flag_i   (branch),
    .branch_target_i (tgt),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_o      (mis),
`endif
    .fetch_bus       (fb)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (1'b0),
    .branch_flag_i   (1'b0),
    .branch_target_i (32'h0),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_o      (mis_w),
`endif
    .fetch_bus       (fbw)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign fb.inst_i  = rom(fb.pc_o);
  assign fbw.inst_i = rom(fbw.pc_o);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the fetch stream as a PC counter plus a bounded queue of expected entries.
  logic        m_ce  = 1'b0;
  logic [31:0] m_pc  = 32'h0;
  int          m_cnt = 0;
  logic        m_mis = 1'b0;
  ent_t        exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ce  = 1'b0;
      m_pc  = 32'h0;
      m_cnt = 0;
      m_mis = 1'b0;
      exp_q.delete();
    end else begin
      m_mis = branch && (tgt[1:0] != 2'b00);
      if (branch) begin
        m_cnt = 0;
        exp_q.delete();
        m_pc  = tgt & ~32'd3;
      end else begin
        bit do_push, do_pop;
        do_push = m_ce && !stall && (m_cnt < DEPTH);
        do_pop  = (m_cnt > 0) && fb.id_ready_i;
        if (do_push) begin
          exp_q.push_back('{pc: m_pc, inst: rom(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
      m_ce = 1'b1;
    end
  end

  // Monitor: compares the DUT against the model and retires entries on each handshake.
  always @(negedge clk) begin
    check("ce_o", {31'b0, fb.ce_o}, {31'b0, m_ce});
    check("pc_o", fb.pc_o, m_pc);
    check("id_valid_o", {31'b0, fb.id_valid_o}, {31'b0, (m_cnt != 0)});
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_o", {31'b0, mis}, {31'b0, m_mis});
`endif
    if (fb.id_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL head_present: got valid entry pc=%h expected empty FIFO at %0t", fb.id_pc_o, $time);
      end else begin
        check("id_pc_o", fb.id_pc_o, exp_q[0].pc);
        check("id_inst_o", fb.id_inst_o, exp_q[0].inst);
        if (fb.id_ready_i && !branch) void'(exp_q.pop_front());
      end
    end else begin
      check("id_pc_empty", fb.id_pc_o, 32'h0);
      check("id_inst_empty", fb.id_inst_o, 32'h0);
    end
  end

  // Wrap-around instance: first four entries must walk FFFF_FFF8 -> 0000_0004.
  logic [31:0] w_exp  = 32'hFFFF_FFF8;
  int          w_seen = 0;

  initial fbw.id_ready_i = 1'b1;

  always @(negedge clk) begin
    if (!rst && fbw.id_valid_o && w_seen < 4) begin
      check("wrap_pc", fbw.id_pc_o, w_exp);
      check("wrap_inst", fbw.id_inst_o, rom(w_exp));
      w_exp = w_exp + 32'd4;
      w_seen++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"}, {31'b0, fb.ce_o}, 32'h0);
    check({tag, "_pc"}, fb.pc_o, 32'h0);
    check({tag, "_valid"}, {31'b0, fb.id_valid_o}, 32'h0);
    check({tag, "_id_pc"}, fb.id_pc_o, 32'h0);
    check({tag, "_id_inst"}, fb.id_inst_o, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check({tag, "_mis"}, {31'b0, mis}, 32'h0);
`endif
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch        = 1'b0;
    tgt           = 32'h0;
    fb.id_ready_i = 1'b1;
    #2;
    check_reset_outputs("reset");
    cyc(2);
    rst = 1'b0;

    // Streaming with ID always ready.
    cyc(6);

    // Backpressure: FIFO saturates, PC holds, then drains in order.
    fb.id_ready_i = 1'b0;
    cyc(5);
    check("bp_pc_held", fb.pc_o, m_pc);
    fb.id_ready_i = 1'b1;
    cyc(4);

    // Stall with two entries buffered: ID still drains them.
    fb.id_ready_i = 1'b0;
    cyc(3);
    stall         = 1'b1;
    fb.id_ready_i = 1'b1;
    cyc(3);
    check("stall_drained", {31'b0, fb.id_valid_o}, 32'h0);
    stall = 1'b0;
    cyc(2);

    // Branch while full and stalled.
    fb.id_ready_i = 1'b0;
    cyc(4);
    stall  = 1'b1;
    branch = 1'b1;
    tgt    = 32'h0000_0100;
    cyc(1);
    branch = 1'b0;
    check("br_valid", {31'b0, fb.id_valid_o}, 32'h0);
    check("br_pc", fb.pc_o, 32'h0000_0100);
    stall         = 1'b0;
    fb.id_ready_i = 1'b1;
    cyc(4);

    // Unaligned branch target gets force-aligned.
    branch = 1'b1;
    tgt    = 32'h0000_0103;
    cyc(1);
    branch = 1'b0;
    check("mis_pc", fb.pc_o, 32'h0000_0100);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flag", {31'b0, mis}, 32'h1);
    cyc(1);
    check("mis_clear", {31'b0, mis}, 32'h0);
`endif
    cyc(3);

    // Randomized traffic with one asynchronous reset in mid-burst.
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 99) < 25);
      fb.id_ready_i = ($urandom_range(0, 99) < 60);
      branch        = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: tgt = $urandom & 32'h0000_0FFF;
      endcase
      if (i == 300) begin
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cyc(2);
        rst = 1'b0;
      end
      cyc(1);
    end

    stall         = 1'b0;
    branch        = 1'b0;
    fb.id_ready_i = 1'b1;
    cyc(6);
    check("wrap_count", w_seen, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
